row_op_sequencer: RTL and testbench

- Controller that sequences one register-row array (ROWS rows of N-bit compute cells) to execute row-to-row operations: dst = src_a OP src_b.
- Accepts one command at a time over a valid/ready handshake.
- Drives the per-row one-hot read/write bus selects, write enables, the shared op_fa code and first_carry.
- Captures the carry and signed-overflow flags from the destination row and reports completion with a one-cycle done pulse.

---
 rtl/row_op_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_row_op_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_op_sequencer.sv
// Row-op sequencer: drives one register-row array through LOAD/EXEC to compute dst = a OP b.
// Optional carry chaining (ADC, op 5) is enabled by defining ROW_OP_SEQ_CARRY_CHAIN_EN.
module row_op_sequencer #(
    parameter int ROWS = 8,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [RW-1:0]   cmd_src_a,
    input  logic [RW-1:0]   cmd_src_b,
    input  logic [RW-1:0]   cmd_dst,
    input  logic [ROWS-1:0] row_overflow,
    input  logic [ROWS-1:0] row_last_carry,
    output logic [ROWS-1:0] rd_sel_up,
    output logic [ROWS-1:0] wr_sel_up,
    output logic [ROWS-1:0] rd_sel_dn,
    output logic [ROWS-1:0] wr_sel_dn,
    output logic [ROWS-1:0] wr_en,
    output logic [3:0]      op_fa,
    output logic            first_carry,
    output logic            done,
    output logic            err,
    output logic            flag_c,
    output logic            flag_v
);
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, FIN} state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_COPY = 3'd4;
    localparam logic [2:0] OP_ADC  = 3'd5;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [RW-1:0]   a_q, a_d, b_q, b_d, dst_q, dst_d;
    logic [ROWS-1:0] rd_up_q, rd_up_d, wr_up_q, wr_up_d;
    logic [ROWS-1:0] rd_dn_q, rd_dn_d, wr_dn_q, wr_dn_d, wr_en_q, wr_en_d;
    logic [3:0]      op_fa_q, op_fa_d;
    logic            done_q, done_d, err_q, err_d;
    logic            flag_c_q, flag_c_d, flag_v_q, flag_v_d;
    logic            op_legal, cmd_bad, swap;

    function automatic logic [ROWS-1:0] onehot(input logic [RW-1:0] idx);
        logic [ROWS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] fa_code(input logic [2:0] op);
        case (op)
            OP_ADD, OP_ADC: return 4'b0001;
            OP_AND:         return 4'b0010;
            OP_XOR:         return 4'b0100;
            OP_OR:          return 4'b1000;
            default:        return 4'b0000;
        endcase
    endfunction

`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
    logic fc_q, fc_d;
    assign op_legal    = (cmd_op <= OP_ADC);
    assign first_carry = fc_q;
`else
    assign op_legal    = (cmd_op <= OP_COPY);
    assign first_carry = 1'b0;
`endif

    // COPY never reads B, so an out-of-range B does not reject it.
    assign cmd_bad = !op_legal
                   || (32'(cmd_src_a) >= ROWS)
                   || (32'(cmd_dst) >= ROWS)
                   || ((cmd_op != OP_COPY) && (32'(cmd_src_b) >= ROWS));

    // Writing dst during LOAD would destroy B when dst == B; ops commute, so read B first instead.
    assign swap = (cmd_op != OP_COPY) && (cmd_dst == cmd_src_b) && (cmd_dst != cmd_src_a);

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dst_d    = dst_q;
        rd_up_d  = '0;
        wr_up_d  = '0;
        rd_dn_d  = '0;
        wr_dn_d  = '0;
        wr_en_d  = '0;
        op_fa_d  = 4'b0000;
        done_d   = 1'b0;
        err_d    = 1'b0;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
        fc_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    a_d   = swap ? cmd_src_b : cmd_src_a;
                    b_d   = swap ? cmd_src_a : cmd_src_b;
                    dst_d = cmd_dst;
                    if (cmd_bad) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        rd_up_d = onehot(a_d);
                        wr_up_d = onehot(dst_d);
                        wr_en_d = onehot(dst_d);
                    end
                end
            end
            LOAD: begin
                if (op_q == OP_COPY) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = EXEC;
                    rd_dn_d = onehot(b_q);
                    wr_dn_d = onehot(dst_q);
                    wr_en_d = onehot(dst_q);
                    op_fa_d = fa_code(op_q);
`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
                    fc_d    = (op_q == OP_ADC) && flag_c_q;
`endif
                end
            end
            EXEC: begin
                state_d = FIN;
                done_d  = 1'b1;
                if ((op_q == OP_ADD) || (op_q == OP_ADC)) begin
                    flag_c_d = row_overflow[dst_q];
                    flag_v_d = row_overflow[dst_q] ^ row_last_carry[dst_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            rd_up_q  <= '0;
            wr_up_q  <= '0;
            rd_dn_q  <= '0;
            wr_dn_q  <= '0;
            wr_en_q  <= '0;
            op_fa_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
            fc_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dst_q    <= dst_d;
            rd_up_q  <= rd_up_d;
            wr_up_q  <= wr_up_d;
            rd_dn_q  <= rd_dn_d;
            wr_dn_q  <= wr_dn_d;
            wr_en_q  <= wr_en_d;
            op_fa_q  <= op_fa_d;
            done_q   <= done_d;
            err_q    <= err_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
            fc_q     <= fc_d;
`endif
        end
    end

    assign rd_sel_up = rd_up_q;
    assign wr_sel_up = wr_up_q;
    assign rd_sel_dn = rd_dn_q;
    assign wr_sel_dn = wr_dn_q;
    assign wr_en     = wr_en_q;
    assign op_fa     = op_fa_q;
    assign done      = done_q;
    assign err       = err_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_row_op_sequencer.sv
// Bench for row_op_sequencer: an 8-bit row array is attached, commands are checked cycle by cycle.
module tb_row_op_sequencer;
    localparam int ROWS = 12;
    localparam int RW   = 4;
    localparam int N    = 8;
`ifdef ROW_OP_SEQ_CARRY_CHAIN_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready;
    logic [2:0]      cmd_op;
    logic [RW-1:0]   cmd_src_a, cmd_src_b, cmd_dst;
    logic [ROWS-1:0] row_overflow, row_last_carry;
    logic [ROWS-1:0] rd_sel_up, wr_sel_up, rd_sel_dn, wr_sel_dn, wr_en;
    logic [3:0]      op_fa;
    logic            first_carry, done, err, flag_c, flag_v;

    int n_cmp = 0;
    int n_bad = 0;
    logic ref_c, ref_v;

    always #5 clk = ~clk;

    row_op_sequencer #(.ROWS(ROWS), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .row_overflow(row_overflow), .row_last_carry(row_last_carry),
        .rd_sel_up(rd_sel_up), .wr_sel_up(wr_sel_up),
        .rd_sel_dn(rd_sel_dn), .wr_sel_dn(wr_sel_dn), .wr_en(wr_en),
        .op_fa(op_fa), .first_carry(first_carry), .done(done), .err(err),
        .flag_c(flag_c), .flag_v(flag_v)
    );

    // Attached row array: buses, per-row adder carries, and write-back
    logic [N-1:0]  rows [ROWS];
    logic          pl_en = 1'b0;
    logic [RW-1:0] pl_row = '0;
    logic [N-1:0]  pl_val = '0;
    logic [N-1:0]  bus_up, bus_dn;

    always_comb begin
        bus_up = '0;
        bus_dn = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_sel_up[r]) bus_up = bus_up | rows[r];
            if (rd_sel_dn[r]) bus_dn = bus_dn | rows[r];
        end
    end

    always_comb begin
        logic [N:0]   s;
        logic [N-1:0] lo;
        s = '0;
        lo = '0;
        row_overflow = '0;
        row_last_carry = '0;
        for (int r = 0; r < ROWS; r++) begin
            s  = {1'b0, rows[r]} + {1'b0, bus_dn} + (N+1)'(first_carry);
            lo = {1'b0, rows[r][N-2:0]} + {1'b0, bus_dn[N-2:0]} + N'(first_carry);
            row_overflow[r]   = s[N];
            row_last_carry[r] = lo[N-1];
        end
    end

    always @(posedge clk) begin
        if (pl_en) rows[pl_row] <= pl_val;
        for (int r = 0; r < ROWS; r++) begin
            if (wr_en[r]) begin
                if (wr_sel_up[r]) rows[r] <= bus_up;
                else if (wr_sel_dn[r]) begin
                    case (op_fa)
                        4'b0001: rows[r] <= rows[r] + bus_dn + N'(first_carry);
                        4'b0010: rows[r] <= rows[r] & bus_dn;
                        4'b0100: rows[r] <= rows[r] ^ bus_dn;
                        4'b1000: rows[r] <= rows[r] | bus_dn;
                        default: rows[r] <= bus_dn;
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_sel();
        return 64'({rd_sel_up, wr_sel_up, rd_sel_dn, wr_sel_dn, wr_en});
    endfunction

    function automatic logic [ROWS-1:0] oh(input int i);
        return ROWS'(1) << i;
    endfunction

    task automatic set_row(input int r, input logic [N-1:0] v);
        pl_en = 1'b1; pl_row = RW'(r); pl_val = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one command and check every cycle against what the op should do.
    task automatic run(input string nm, input int op, input int a, input int b, input int d);
        logic [N-1:0] snap [ROWS];
        logic [N-1:0] va, vb, expv;
        logic [N:0]   sum;
        logic         bad, sw, is_add, cin, ec, ev;
        int           ea, eb, others;
        logic [3:0]   code;
        bad    = !((op <= 4) || (op == 5 && FEAT)) || a >= ROWS || d >= ROWS || (op != 4 && b >= ROWS);
        sw     = (op != 4) && (d == b) && (d != a);
        ea     = sw ? b : a;
        eb     = sw ? a : b;
        is_add = (op == 0) || (op == 5);
        cin    = (op == 5) ? ref_c : 1'b0;
        for (int r = 0; r < ROWS; r++) snap[r] = rows[r];
        va = (a < ROWS) ? snap[a] : '0;
        vb = (b < ROWS) ? snap[b] : '0;
        sum  = {1'b0, va} + {1'b0, vb} + (N+1)'(cin);
        case (op)
            1:       begin expv = va & vb; code = 4'b0010; end
            2:       begin expv = va ^ vb; code = 4'b0100; end
            3:       begin expv = va | vb; code = 4'b1000; end
            4:       begin expv = va;      code = 4'b0000; end
            default: begin expv = sum[N-1:0]; code = 4'b0001; end
        endcase
        ec = ref_c; ev = ref_v;
        if (!bad && is_add) begin
            ec = sum[N];
            ev = (va[N-1] == vb[N-1]) && (sum[N-1] != va[N-1]);
        end

        chk({nm, ".ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_op = 3'(op);
        cmd_src_a = RW'(a); cmd_src_b = RW'(b); cmd_dst = RW'(d);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_src_a = RW'($urandom); cmd_src_b = RW'($urandom); cmd_dst = RW'($urandom);

        if (bad) begin
            chk({nm, ".err_done"}, 64'({done, err}), 64'(2'b11));
            chk({nm, ".err_sel"}, all_sel(), 64'(0));
        end else begin
            chk({nm, ".load_rd_up"}, 64'(rd_sel_up), 64'(oh(ea)));
            chk({nm, ".load_wr"}, 64'({wr_sel_up, wr_en}), 64'({oh(d), oh(d)}));
            chk({nm, ".load_misc"}, 64'({rd_sel_dn, wr_sel_dn, op_fa, done, cmd_ready}), 64'(0));
            @(posedge clk); #1;
            if (op != 4) begin
                chk({nm, ".exec_rd_dn"}, 64'(rd_sel_dn), 64'(oh(eb)));
                chk({nm, ".exec_wr"}, 64'({wr_sel_dn, wr_en, rd_sel_up, wr_sel_up}),
                    64'({oh(d), oh(d), ROWS'(0), ROWS'(0)}));
                chk({nm, ".exec_fa_fc"}, 64'({op_fa, first_carry, done}), 64'({code, cin, 1'b0}));
                @(posedge clk); #1;
            end
            chk({nm, ".done"}, 64'({done, err}), 64'(2'b10));
            chk({nm, ".done_sel"}, all_sel(), 64'(0));
            chk({nm, ".result"}, 64'(rows[d]), 64'(expv));
            others = 0;
            for (int r = 0; r < ROWS; r++) if (r != d && rows[r] !== snap[r]) others++;
            chk({nm, ".others"}, 64'(others), 64'(0));
        end
        chk({nm, ".flags"}, 64'({flag_c, flag_v}), 64'({ec, ev}));
        ref_c = ec; ref_v = ev;
        chk({nm, ".busy"}, 64'(cmd_ready), 64'(0));
        @(posedge clk); #1;
        chk({nm, ".back_idle"}, 64'({cmd_ready, done}), 64'(2'b10));
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        ref_c = 1'b0; ref_v = 1'b0;
        for (int r = 0; r < ROWS; r++) rows[r] = N'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.sel", all_sel(), 64'(0));
        chk("reset.out", 64'({op_fa, first_carry, done, err, flag_c, flag_v}), 64'(0));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("reset.ready", 64'(cmd_ready), 64'(1));

        set_row(1, 8'hF0); set_row(2, 8'h20);
        run("add", 0, 1, 2, 3);
        chk("add.const", 64'({rows[3], flag_c, flag_v}), 64'({8'h10, 2'b10}));

        set_row(4, 8'h7F); set_row(5, 8'h01);
        run("swap", 0, 4, 5, 5);
        chk("swap.const", 64'({rows[5], flag_c, flag_v}), 64'({8'h80, 2'b01}));

        run("copy", 4, 0, 0, 7);
        run("bad_dst", 0, 1, 2, ROWS);
        run("bad_op", 7, 1, 2, 3);
        run("bad_op6", 6, 1, 2, 3);

        // Abort in EXEC: LOAD has already copied A into dst, flags clear.
        set_row(1, 8'h33); set_row(2, 8'h44);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_src_a = 4'd1; cmd_src_b = 4'd2; cmd_dst = 4'd6;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.in_exec", 64'(rd_sel_dn), 64'(oh(2)));
        #2 rst = 1'b0;
        #1;
        chk("abort.sel", all_sel(), 64'(0));
        chk("abort.out", 64'({op_fa, first_carry, done, err, flag_c, flag_v}), 64'(0));
        chk("abort.partial_dst", 64'(rows[6]), 64'(8'h33));
        ref_c = 1'b0; ref_v = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.ready", 64'(cmd_ready), 64'(1));
        run("post_reset", 2, 1, 2, 6);

        set_row(8, 8'hFF); set_row(9, 8'h01);
        run("chain_lo", 0, 8, 9, 8);
        set_row(10, 8'h00); set_row(11, 8'h00);
        run("chain_adc", 5, 10, 11, 10);

        for (int i = 0; i < 40; i++) begin
            int op, a, b, d;
            if ($urandom_range(0, 2) == 0) set_row($urandom_range(0, ROWS - 1), N'($urandom));
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, ROWS);
            b  = (op == 4) ? $urandom_range(0, ROWS - 1) : $urandom_range(0, ROWS);
            d  = $urandom_range(0, ROWS);
            if ($urandom_range(0, 3) == 0) d = b;
            run($sformatf("rnd%0d", i), op, a, b, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
